// File: rtl/shared_adder_pkg.sv
// Shared types for the round-robin shared adder: FSM state encoding and id-width helper.
package shared_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Ceiling log2, never below 1 so a single-bit id field always exists.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/shared_adder_arb_if.sv
// Requester and response bundle of the shared adder; slave is the adder, master the clients.
interface shared_adder_arb_if
    import shared_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    localparam int IDW = clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_carry;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
    );
endinterface

// File: rtl/shared_adder_arb_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above rr_ptr_i, wrapping; zero latency.
// Pure function of its inputs, so it applies no backpressure of its own.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  rr_ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_idx_o,
    output logic            any_gnt_o
);
    int idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_gnt_o = 1'b0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_i) + k) % NREQ;
            if (!any_gnt_o && req_i[idx]) begin
                any_gnt_o  = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = IDW'(idx);
            end
        end
    end
endmodule

// File: rtl/shared_adder_arb.sv
// One adder shared round-robin by NREQ requesters; accept->rsp_valid 2 cycles, one result per 3 cycles.
// rsp_ready low parks the result in RESP and blocks new grants; SHARED_ADDER_SAT_EN saturates on carry.
module shared_adder_arb
    import shared_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    shared_adder_arb_if.slave bus
);
    localparam int IDW = clog2(NREQ);

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   op_id_q, op_id_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;

    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_idx;
    logic             any_gnt;
    logic [WIDTH:0]   full_sum;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req_i     (bus.req_valid),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_gnt_o (any_gnt)
    );

    assign full_sum = {1'b0, op_a_q} + {1'b0, op_b_q};

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        op_id_d  = op_id_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        rsp_id_d = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (any_gnt) begin
                    op_a_d   = bus.req_a[gnt_idx*WIDTH +: WIDTH];
                    op_b_d   = bus.req_b[gnt_idx*WIDTH +: WIDTH];
                    op_id_d  = gnt_idx;
                    rr_ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);
                    state_d  = ADD;
                end
            end
            ADD: begin
`ifdef SHARED_ADDER_SAT_EN
                sum_d = full_sum[WIDTH] ? '1 : full_sum[WIDTH-1:0];
`else
                sum_d = full_sum[WIDTH-1:0];
`endif
                carry_d  = full_sum[WIDTH];
                rsp_id_d = op_id_q;
                state_d  = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            op_id_q  <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            rsp_id_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            op_id_q  <= op_id_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            rsp_id_q <= rsp_id_d;
        end
    end

    // Ready is gated by reset so nothing looks accepted on a reset edge.
    assign bus.req_ready = (state_q == IDLE && rst_n) ? gnt : '0;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_carry = carry_q;
    assign bus.rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_shared_adder_arb.sv
// Directed bench for shared_adder_arb with a response scoreboard and grant-order log.
module tb_shared_adder_arb;
    localparam int W = 8;
    localparam int N = 4;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] sum;
        logic       carry;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    int   grants[$];

    shared_adder_arb_if #(.WIDTH(W), .NREQ(N)) bus ();

    shared_adder_arb #(.WIDTH(W), .NREQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int id);
        exp_t e;
        logic [8:0] full;
        full    = {1'b0, a} + {1'b0, b};
        e.id    = 2'(id);
        e.carry = full[8];
        e.sum   = full[7:0];
`ifdef SHARED_ADDER_SAT_EN
        if (full[8]) e.sum = 8'hFF;
`endif
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Observe the current cycle: log accepts into the scoreboard, retire handshaken results.
    task automatic settle();
        exp_t e;
        #1;
        if (rst_n) begin
            chk("ready_onehot", 32'($countones(bus.req_ready) <= 1), 1);
            for (int i = 0; i < N; i++) begin
                if (bus.req_ready[i]) begin
                    chk("ready_needs_valid", 32'(bus.req_valid[i]), 1);
                    sb.push_back(model(bus.req_a[i*W +: W], bus.req_b[i*W +: W], i));
                    grants.push_back(i);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                chk("rsp_expected", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                    chk("rsp_sum", 32'(bus.rsp_sum), 32'(e.sum));
                    chk("rsp_carry", 32'(bus.rsp_carry), 32'(e.carry));
                end
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle();
        adv();
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
    endtask

    // Leaves the bench at the settle point of the first cycle with rsp_valid high.
    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        settle();
        while (!bus.rsp_valid && n < 10) begin
            adv();
            settle();
            n++;
        end
        chk({tag, "_timeout"}, 32'(bus.rsp_valid), 1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            cycle();
            n++;
        end
        chk({tag, "_drain"}, 32'(sb.size()), 0);
        cycle();
    endtask

    task automatic run_one(input int i, input logic [7:0] a, input logic [7:0] b);
        set_req(i, a, b);
        bus.req_valid = 4'(1 << i);
        settle();
        chk("run_one_ready", 32'(bus.req_ready), 32'(1 << i));
        adv();
        bus.req_valid = '0;
        drain("run_one");
    endtask

    initial begin
        int n;
        rst_n         = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_sum", 32'(bus.rsp_sum), 0);
        chk("rst_rsp_carry", 32'(bus.rsp_carry), 0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        bus.req_valid = '0;
        rst_n         = 1'b1;
        adv();

        // Single requester, latency of two cycles.
        bus.rsp_ready = 1'b1;
        set_req(2, 8'h12, 8'h34);
        bus.req_valid = 4'b0100;
        settle();
        chk("single_ready", 32'(bus.req_ready), 32'h4);
        adv();
        bus.req_valid = '0;
        settle();
        chk("single_ready_pulse", 32'(bus.req_ready), 0);
        chk("single_lat_n1", 32'(bus.rsp_valid), 0);
        adv();
        settle();
        chk("single_lat_n2", 32'(bus.rsp_valid), 1);
        chk("single_sum", 32'(bus.rsp_sum), 32'h46);
        chk("single_carry", 32'(bus.rsp_carry), 0);
        chk("single_id", 32'(bus.rsp_id), 2);
        adv();
        drain("single");

        // Overflow on requester 0.
        set_req(0, 8'hF0, 8'h20);
        bus.req_valid = 4'b0001;
        settle();
        chk("ovf_ready", 32'(bus.req_ready), 32'h1);
        adv();
        bus.req_valid = '0;
        wait_rsp("ovf");
        chk("ovf_carry", 32'(bus.rsp_carry), 1);
`ifdef SHARED_ADDER_SAT_EN
        chk("ovf_sum", 32'(bus.rsp_sum), 32'hFF);
`else
        chk("ovf_sum", 32'(bus.rsp_sum), 32'h10);
`endif
        adv();
        drain("ovf");

        // Sparse: move pointer to 2, then only 1 and 3 valid.
        run_one(1, 8'h05, 8'h06);
        grants.delete();
        set_req(1, 8'h11, 8'h22);
        set_req(3, 8'h80, 8'h90);
        bus.req_valid = 4'b1010;
        n = 0;
        while (grants.size() < 2 && n < 20) begin
            cycle();
            n++;
        end
        bus.req_valid = '0;
        chk("sparse_count", 32'(grants.size()), 2);
        if (grants.size() >= 2) begin
            chk("sparse_first", 32'(grants[0]), 3);
            chk("sparse_second", 32'(grants[1]), 1);
        end
        drain("sparse");

        // All four valid from pointer 0: order 0,1,2,3,0.
        run_one(3, 8'h01, 8'h01);
        grants.delete();
        for (int i = 0; i < N; i++) set_req(i, 8'(8'h10 * i + 3), 8'(8'hC0 + i));
        bus.req_valid = 4'hF;
        n = 0;
        while (grants.size() < 5 && n < 40) begin
            cycle();
            n++;
        end
        bus.req_valid = '0;
        chk("rr_count", 32'(grants.size()), 5);
        for (int i = 0; i < 5 && i < grants.size(); i++)
            chk("rr_order", 32'(grants[i]), 32'(i % N));
        drain("rr");

        // Backpressure: result held five cycles while requester 1 waits.
        set_req(0, 8'h01, 8'h02);
        set_req(1, 8'h07, 8'h08);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0001;
        settle();
        chk("bp_ready", 32'(bus.req_ready), 32'h1);
        adv();
        bus.req_valid = 4'b0010;
        wait_rsp("bp");
        for (int k = 0; k < 5; k++) begin
            if (k > 0) settle();
            chk("bp_valid", 32'(bus.rsp_valid), 1);
            chk("bp_sum", 32'(bus.rsp_sum), 32'h03);
            chk("bp_id", 32'(bus.rsp_id), 0);
            chk("bp_no_grant", 32'(bus.req_ready), 0);
            adv();
        end
        bus.rsp_ready = 1'b1;
        settle();
        chk("bp_retire_no_grant", 32'(bus.req_ready), 0);
        adv();
        settle();
        chk("bp_next_grant", 32'(bus.req_ready), 32'h2);
        adv();
        bus.req_valid = '0;
        drain("bp");

        // Reset during ADD discards the result and clears the pointer.
        set_req(2, 8'h33, 8'h44);
        bus.req_valid = 4'b0100;
        settle();
        chk("rstmid_ready", 32'(bus.req_ready), 32'h4);
        adv();
        bus.req_valid = '0;
        rst_n = 1'b0;
        sb.delete();
        settle();
        adv();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("rstmid_no_rsp", 32'(bus.rsp_valid), 0);
            adv();
        end
        set_req(0, 8'h02, 8'h02);
        set_req(3, 8'h04, 8'h04);
        bus.req_valid = 4'hF;
        settle();
        chk("rstmid_grant0", 32'(bus.req_ready), 32'h1);
        adv();
        bus.req_valid = '0;
        drain("rstmid");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
